// File: rtl/meteor_spawn_scheduler_if.sv
// Bus between the game controller and the meteor spawn scheduler:
// run enable, frame pulses, slot releases in; spawn commands and status out.
interface meteor_spawn_scheduler_if #(
    parameter int NUM_SLOTS = 8
);
    localparam int IDX_W = $clog2(NUM_SLOTS);

    logic                 game_screen;
    logic                 frame_tick;
    logic                 free_valid;
    logic [IDX_W-1:0]     free_idx;
    logic                 spawn_valid;
    logic [IDX_W-1:0]     spawn_idx;
    logic [9:0]           spawn_x;
    logic [NUM_SLOTS-1:0] active_mask;
    logic [3:0]           level;

    modport master (
        output game_screen, frame_tick, free_valid, free_idx,
        input  spawn_valid, spawn_idx, spawn_x, active_mask, level
    );

    modport slave (
        input  game_screen, frame_tick, free_valid, free_idx,
        output spawn_valid, spawn_idx, spawn_x, active_mask, level
    );
endinterface

// File: rtl/meteor_spawn_scheduler.sv
// Meteor spawn scheduler: counts frames, picks a free slot round-robin, issues a
// spawn with a pseudo-random x position and ramps difficulty every few spawns.
module meteor_spawn_scheduler #(
    parameter int NUM_SLOTS     = 8,
    parameter int INIT_INTERVAL = 60,
    parameter int MIN_INTERVAL  = 15,
    parameter int RAMP_EVERY    = 10,
    parameter int STEP          = 5
) (
    input  logic                    Clk,
    input  logic                    Reset,
    meteor_spawn_scheduler_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_SLOTS);
    localparam int CNT_W = $clog2(INIT_INTERVAL + 1);
    localparam int SC_W  = $clog2(RAMP_EVERY + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_SEARCH = 2'd2;
    localparam logic [1:0] ST_ISSUE  = 2'd3;

    localparam logic [CNT_W-1:0] INIT_C    = CNT_W'(INIT_INTERVAL);
    localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_INTERVAL);
    localparam logic [CNT_W-1:0] STEP_C    = CNT_W'(STEP);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [SC_W-1:0]  RAMP_LAST = SC_W'(RAMP_EVERY - 1);
    localparam logic [15:0]      LFSR_SEED = 16'hACE1;
    localparam logic [9:0]       X_MAX     = 10'd607;
    localparam logic [9:0]       X_FOLD    = 10'd512;
    localparam logic [3:0]       LEVEL_MAX = 4'd15;

    logic [1:0]           state_q,       state_d;
    logic [CNT_W-1:0]     countdown_q,   countdown_d;
    logic [CNT_W-1:0]     interval_q,    interval_d;
    logic [SC_W-1:0]      spawn_count_q, spawn_count_d;
    logic [3:0]           level_q,       level_d;
    logic [IDX_W-1:0]     rr_ptr_q,      rr_ptr_d;
    logic [NUM_SLOTS-1:0] active_mask_q, active_mask_d;
    logic [15:0]          lfsr_q,        lfsr_d;
    logic                 spawn_valid_q, spawn_valid_d;
    logic [IDX_W-1:0]     spawn_idx_q,   spawn_idx_d;
    logic [9:0]           spawn_x_q,     spawn_x_d;

    logic                 scan_found;
    logic [IDX_W-1:0]     scan_idx;
    logic [CNT_W:0]       interval_dec;
    logic [CNT_W-1:0]     interval_ramped;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // Extra top bit flags underflow so a large STEP still clamps to the floor.
    assign interval_dec    = {1'b0, interval_q} - {1'b0, STEP_C};
    assign interval_ramped = (interval_dec[CNT_W] || (interval_dec[CNT_W-1:0] < MIN_C))
                             ? MIN_C : interval_dec[CNT_W-1:0];

    // NOTE: every variable written in an always_comb gets a default at the top,
    // so no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        logic [IDX_W-1:0] cand;
        scan_found = 1'b0;
        scan_idx   = '0;
        cand       = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            cand = rr_ptr_q + IDX_W'(i);
            if (!scan_found && !active_mask_q[cand]) begin
                scan_found = 1'b1;
                scan_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        countdown_d   = countdown_q;
        interval_d    = interval_q;
        spawn_count_d = spawn_count_q;
        level_d       = level_q;
        rr_ptr_d      = rr_ptr_q;
        active_mask_d = active_mask_q;
        spawn_valid_d = 1'b0;
        spawn_idx_d   = spawn_idx_q;
        spawn_x_d     = spawn_x_q;

        // Leaving play acts at once: the game state is wiped on the same edge.
        if (!bus.game_screen || state_q == ST_IDLE) begin
            active_mask_d = '0;
            level_d       = '0;
            countdown_d   = INIT_C;
            interval_d    = INIT_C;
            spawn_count_d = '0;
            rr_ptr_d      = '0;
            state_d       = bus.game_screen ? ST_WAIT : ST_IDLE;
        end else begin
            if (bus.free_valid) begin
                active_mask_d[bus.free_idx] = 1'b0;
            end
            case (state_q)
                ST_WAIT: begin
                    if (bus.frame_tick) begin
                        if (countdown_q == ONE_C) begin
                            state_d = ST_SEARCH;
                        end else begin
                            countdown_d = countdown_q - ONE_C;
                        end
                    end
                end
                ST_SEARCH: begin
                    if (scan_found) begin
                        state_d       = ST_ISSUE;
                        spawn_valid_d = 1'b1;
                        spawn_idx_d   = scan_idx;
                        // lfsr_d is the value the LFSR holds during the ISSUE cycle.
                        spawn_x_d     = (lfsr_d[9:0] > X_MAX) ? lfsr_d[9:0] - X_FOLD : lfsr_d[9:0];
                    end else begin
                        countdown_d = ONE_C;
                        state_d     = ST_WAIT;
                    end
                end
                ST_ISSUE: begin
                    active_mask_d[spawn_idx_q] = 1'b1;
                    rr_ptr_d                   = spawn_idx_q + IDX_W'(1);
                    if (spawn_count_q == RAMP_LAST) begin
                        spawn_count_d = '0;
                        interval_d    = interval_ramped;
                        level_d       = (level_q == LEVEL_MAX) ? level_q : level_q + 4'd1;
                    end else begin
                        spawn_count_d = spawn_count_q + SC_W'(1);
                    end
                    // The gap after a ramping spawn already uses the shorter interval.
                    countdown_d = interval_d;
                    state_d     = ST_WAIT;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // its _d value from before the edge, independent of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            countdown_q   <= INIT_C;
            interval_q    <= INIT_C;
            spawn_count_q <= '0;
            level_q       <= '0;
            rr_ptr_q      <= '0;
            active_mask_q <= '0;
            lfsr_q        <= LFSR_SEED;
            spawn_valid_q <= 1'b0;
            spawn_idx_q   <= '0;
            spawn_x_q     <= '0;
        end else begin
            state_q       <= state_d;
            countdown_q   <= countdown_d;
            interval_q    <= interval_d;
            spawn_count_q <= spawn_count_d;
            level_q       <= level_d;
            rr_ptr_q      <= rr_ptr_d;
            active_mask_q <= active_mask_d;
            lfsr_q        <= lfsr_d;
            spawn_valid_q <= spawn_valid_d;
            spawn_idx_q   <= spawn_idx_d;
            spawn_x_q     <= spawn_x_d;
        end
    end

    assign bus.spawn_valid = spawn_valid_q;
    assign bus.spawn_idx   = spawn_idx_q;
    assign bus.spawn_x     = spawn_x_q;
    assign bus.active_mask = active_mask_q;
    assign bus.level       = level_q;
endmodule

// File: tb/tb_meteor_spawn_scheduler.sv
// Self-checking bench for meteor_spawn_scheduler: reset/idle vector table, then
// frame-level randomized stimulus against a slot/interval/level model.
module tb_meteor_spawn_scheduler;
    localparam int NS        = 8;
    localparam int INIT_IV   = 60;
    localparam int MIN_IV    = 15;
    localparam int RAMP      = 10;
    localparam int STEP_IV   = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    meteor_spawn_scheduler_if #(.NUM_SLOTS(NS)) bus ();

    meteor_spawn_scheduler #(
        .NUM_SLOTS(NS), .INIT_INTERVAL(INIT_IV), .MIN_INTERVAL(MIN_IV),
        .RAMP_EVERY(RAMP), .STEP(STEP_IV)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model of the game state, tracked per frame
    logic [7:0] m_mask;
    int         m_rr, m_cd, m_interval, m_count, m_level;
    int         m_last_idx, m_last_x;
    int         g_frame;

    // Free-running pseudo-random source: taps 16,14,13,11 from seed ACE1
    logic [15:0] tb_lfsr;
    always @(posedge clk) begin
        if (rst) tb_lfsr <= 16'hACE1;
        else     tb_lfsr <= {tb_lfsr[14:0], tb_lfsr[15] ^ tb_lfsr[13] ^ tb_lfsr[12] ^ tb_lfsr[10]};
    end

    typedef struct {
        string      name;
        bit         rst, gs, tick, fv;
        logic [2:0] fidx;
        bit         e_valid;
        logic [2:0] e_idx;
        logic [9:0] e_x;
        logic [7:0] e_mask;
        logic [3:0] e_level;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int fold_x(input logic [9:0] v);
        return (v > 10'd607) ? int'(v) - 512 : int'(v);
    endfunction

    task automatic m_init();
        m_mask = '0; m_rr = 0; m_cd = INIT_IV; m_interval = INIT_IV;
        m_count = 0; m_level = 0;
    endtask

    task automatic drive_free(input bit en, input int idx);
        bus.free_valid = en;
        bus.free_idx   = 3'(idx);
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.game_screen = 1'b0; bus.frame_tick = 1'b0; drive_free(1'b0, 0);
        cyc();
        rst = 1'b0;
        m_init(); m_last_idx = 0; m_last_x = 0; g_frame = 0;
    endtask

    task automatic start_game();
        bus.game_screen = 1'b1;
        cyc();
        m_init();
        check("start_mask", 32'(bus.active_mask), 32'(m_mask));
    endtask

    // One frame = 4 cycles: tick, search, issue, idle. fphase picks the cycle
    // (0..3) carrying a free_valid for slot fidx, or -1 for none.
    task automatic run_frame(input int fphase, input int fidx, output bit spawned);
        bit do_search, exp_spawn;
        int exp_idx;
        bus.frame_tick = 1'b1;
        drive_free(fphase == 0, fidx);
        cyc();
        bus.frame_tick = 1'b0;
        drive_free(1'b0, 0);
        if (fphase == 0) m_mask[fidx] = 1'b0;
        do_search = (m_cd == 1);
        if (!do_search) m_cd--;
        exp_spawn = 1'b0; exp_idx = 0;
        if (do_search) begin
            for (int k = 0; k < NS; k++) begin
                int j;
                j = (m_rr + k) % NS;
                if (!exp_spawn && !m_mask[j]) begin exp_spawn = 1'b1; exp_idx = j; end
            end
        end
        check("tick_no_valid", 32'(bus.spawn_valid), 0);

        drive_free(fphase == 1, fidx);
        cyc();
        drive_free(1'b0, 0);
        if (do_search && !exp_spawn) m_cd = 1;
        if (fphase == 1) m_mask[fidx] = 1'b0;
        spawned = bus.spawn_valid;
        check("spawn_valid", 32'(bus.spawn_valid), 32'(exp_spawn));
        if (exp_spawn) begin
            m_last_idx = exp_idx;
            m_last_x   = fold_x(tb_lfsr[9:0]);
        end
        check("spawn_idx", 32'(bus.spawn_idx), 32'(m_last_idx));
        check("spawn_x", 32'(bus.spawn_x), 32'(m_last_x));
        check("spawn_x_range", 32'(bus.spawn_x <= 10'd607), 1);

        drive_free(fphase == 2, fidx);
        cyc();
        drive_free(1'b0, 0);
        if (fphase == 2) m_mask[fidx] = 1'b0;
        if (exp_spawn) begin
            m_mask[exp_idx] = 1'b1;
            m_rr = (exp_idx + 1) % NS;
            m_count++;
            if (m_count == RAMP) begin
                m_count = 0;
                m_interval = (m_interval - STEP_IV < MIN_IV) ? MIN_IV : m_interval - STEP_IV;
                if (m_level < 15) m_level++;
            end
            m_cd = m_interval;
        end
        check("valid_one_cycle", 32'(bus.spawn_valid), 0);
        check("mask_after_issue", 32'(bus.active_mask), 32'(m_mask));
        check("level", 32'(bus.level), 32'(m_level));

        drive_free(fphase == 3, fidx);
        cyc();
        drive_free(1'b0, 0);
        if (fphase == 3) m_mask[fidx] = 1'b0;
        check("mask_after_free", 32'(bus.active_mask), 32'(m_mask));
        g_frame++;
    endtask

    task automatic run_until_cd1();
        bit sp;
        for (int i = 0; i < 200 && m_cd != 1; i++) run_frame(-1, 0, sp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit sp;
        int cnt, spawn_n, prev_frame, gap, fph, first_frame;

        vecs[0] = '{"reset_priority", 1, 1, 1, 1, 3'd3, 0, 3'd0, 10'd0, 8'h00, 4'd0};
        vecs[1] = '{"reset_hold",     1, 0, 0, 0, 3'd0, 0, 3'd0, 10'd0, 8'h00, 4'd0};
        vecs[2] = '{"idle_tick_free", 0, 0, 1, 1, 3'd3, 0, 3'd0, 10'd0, 8'h00, 4'd0};
        vecs[3] = '{"idle_tick",      0, 0, 1, 0, 3'd0, 0, 3'd0, 10'd0, 8'h00, 4'd0};
        vecs[4] = '{"enter_wait",     0, 1, 0, 0, 3'd0, 0, 3'd0, 10'd0, 8'h00, 4'd0};
        vecs[5] = '{"wait_tick",      0, 1, 1, 0, 3'd0, 0, 3'd0, 10'd0, 8'h00, 4'd0};
        vecs[6] = '{"free_clear_nop", 0, 1, 0, 1, 3'd2, 0, 3'd0, 10'd0, 8'h00, 4'd0};
        vecs[7] = '{"leave_play",     0, 0, 0, 0, 3'd0, 0, 3'd0, 10'd0, 8'h00, 4'd0};

        rst = 1'b1; bus.game_screen = 1'b0; bus.frame_tick = 1'b0; drive_free(1'b0, 0);
        for (int v = 0; v < 8; v++) begin
            rst = vecs[v].rst; bus.game_screen = vecs[v].gs; bus.frame_tick = vecs[v].tick;
            drive_free(vecs[v].fv, int'(vecs[v].fidx));
            cyc();
            check({vecs[v].name, "_valid"}, 32'(bus.spawn_valid), 32'(vecs[v].e_valid));
            check({vecs[v].name, "_idx"},   32'(bus.spawn_idx),   32'(vecs[v].e_idx));
            check({vecs[v].name, "_x"},     32'(bus.spawn_x),     32'(vecs[v].e_x));
            check({vecs[v].name, "_mask"},  32'(bus.active_mask), 32'(vecs[v].e_mask));
            check({vecs[v].name, "_level"}, 32'(bus.level),       32'(vecs[v].e_level));
        end

        // First spawn after 60 frames, then fill every slot
        do_reset();
        start_game();
        spawn_n = 0; first_frame = -1;
        for (int i = 0; i < 1000 && spawn_n < 8; i++) begin
            run_frame(-1, 0, sp);
            if (sp) begin
                spawn_n++;
                if (spawn_n == 1) begin
                    first_frame = g_frame;
                    check("first_spawn_frame", 32'(first_frame), 60);
                    check("first_spawn_idx", 32'(bus.spawn_idx), 0);
                    check("first_spawn_mask", 32'(bus.active_mask), 32'h01);
                end
            end
        end
        check("fill_mask", 32'(bus.active_mask), 32'hFF);

        // Full: expiries retry silently; freeing slot 5 lets it respawn
        cnt = 0;
        for (int i = 0; i < 65; i++) begin run_frame(-1, 0, sp); cnt += int'(sp); end
        check("full_no_spawn", 32'(cnt), 0);
        run_frame(3, 5, sp);
        check("full_free_same_frame", 32'(sp), 0);
        run_frame(-1, 0, sp);
        check("retry_spawned", 32'(sp), 1);
        check("retry_idx5", 32'(bus.spawn_idx), 5);
        check("retry_mask", 32'(bus.active_mask), 32'hFF);

        // Free during SEARCH on the only candidate
        run_frame(3, 2, sp);
        run_until_cd1();
        run_frame(1, 2, sp);
        check("search_free_idx", 32'(bus.spawn_idx), 2);
        check("search_free_mask", 32'(bus.active_mask), 32'hFF);

        // Set/clear collision in ISSUE
        run_frame(3, 4, sp);
        run_until_cd1();
        run_frame(2, 4, sp);
        check("collide_idx", 32'(bus.spawn_idx), 4);
        check("collide_mask", 32'(bus.active_mask), 32'hFF);

        // Free in SEARCH with a full registered mask is seen one frame later
        run_until_cd1();
        run_frame(1, 6, sp);
        check("late_free_no_spawn", 32'(sp), 0);
        run_frame(-1, 0, sp);
        check("late_free_spawned", 32'(sp), 1);
        check("late_free_idx", 32'(bus.spawn_idx), 6);

        // Long randomized run through every difficulty step
        do_reset();
        start_game();
        spawn_n = 0; prev_frame = 0;
        while (spawn_n < 165 && g_frame < 6000) begin
            fph = int'($urandom_range(0, 4));
            if (fph == 4) fph = -1;
            run_frame(fph, int'($urandom_range(0, 7)), sp);
            if (sp) begin
                spawn_n++;
                gap = g_frame - prev_frame;
                prev_frame = g_frame;
                if (spawn_n == 1)   check("ramp_first_gap", 32'(gap), 60);
                if (spawn_n == 10)  check("ramp_level1", 32'(bus.level), 1);
                if (spawn_n == 11)  check("ramp_gap_level1", 32'(gap), 55);
                if (spawn_n == 91 || spawn_n == 130) check("ramp_gap_floor", 32'(gap), 15);
                if (spawn_n == 150) check("ramp_level15", 32'(bus.level), 15);
                if (spawn_n == 165) check("ramp_level_sat", 32'(bus.level), 15);
            end
        end
        check("ramp_spawn_budget", 32'(spawn_n), 165);

        // Leaving play from WAIT with every slot occupied
        for (int i = 0; i < 500 && m_mask != 8'hFF; i++) run_frame(-1, 0, sp);
        check("pre_drop_mask", 32'(bus.active_mask), 32'hFF);
        bus.game_screen = 1'b0;
        cyc();
        m_init();
        check("drop_mask", 32'(bus.active_mask), 0);
        check("drop_level", 32'(bus.level), 0);
        check("drop_valid", 32'(bus.spawn_valid), 0);
        check("drop_idx_hold", 32'(bus.spawn_idx), 32'(m_last_idx));
        for (int i = 0; i < 6; i++) begin
            bus.frame_tick = 1'(i % 2);
            cyc();
            check("idle_no_valid", 32'(bus.spawn_valid), 0);
        end
        bus.frame_tick = 1'b0;

        // Leaving play while a spawn is pending in SEARCH
        start_game();
        run_until_cd1();
        bus.frame_tick = 1'b1;
        cyc();
        bus.frame_tick = 1'b0;
        bus.game_screen = 1'b0;
        cyc();
        check("pending_drop_valid", 32'(bus.spawn_valid), 0);
        check("pending_drop_idx", 32'(bus.spawn_idx), 32'(m_last_idx));
        check("pending_drop_x", 32'(bus.spawn_x), 32'(m_last_x));
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("pending_idle_valid", 32'(bus.spawn_valid), 0);
        end

        // Reset while in ISSUE
        start_game();
        run_until_cd1();
        bus.frame_tick = 1'b1;
        cyc();
        bus.frame_tick = 1'b0;
        cyc();
        check("issue_before_reset", 32'(bus.spawn_valid), 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rst_valid", 32'(bus.spawn_valid), 0);
        check("rst_idx", 32'(bus.spawn_idx), 0);
        check("rst_x", 32'(bus.spawn_x), 0);
        check("rst_mask", 32'(bus.active_mask), 0);
        check("rst_level", 32'(bus.level), 0);
        m_init(); m_last_idx = 0; m_last_x = 0; g_frame = 0;
        cyc();
        spawn_n = 0;
        for (int i = 0; i < 100 && spawn_n == 0; i++) begin
            run_frame(-1, 0, sp);
            if (sp) begin
                spawn_n++;
                check("post_rst_frame", 32'(g_frame), 60);
            end
        end
        check("post_rst_spawned", 32'(spawn_n), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/meteor_spawn_scheduler.md
METEOR_SPAWN_SCHEDULER -- requirements
Module: meteor_spawn_scheduler

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 8: number of meteor object slots (power of two).
REQ-002 SHALL have parameter INIT_INTERVAL, default 60: frames between spawns at level 0.
REQ-003 SHALL have parameter MIN_INTERVAL, default 15: floor on the spawn interval.
REQ-004 SHALL have parameter RAMP_EVERY, default 10: number of spawns per difficulty step.
REQ-005 SHALL have parameter STEP, default 5: interval reduction per difficulty step.
REQ-006 SHALL have port Clk, input, 1: sole clock.
REQ-007 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port game_screen, input, 1: high while the game is in play; acts as run enable.
REQ-009 SHALL have port frame_tick, input, 1: one-cycle pulse per video frame.
REQ-010 SHALL have port free_valid, input, 1: one-cycle pulse releasing slot free_idx (meteor destroyed or off-screen).
REQ-011 SHALL have port free_idx, input, log2(NUM_SLOTS): slot to release.
REQ-012 SHALL have port spawn_valid, output, 1: one-cycle pulse commanding a spawn.
REQ-013 SHALL have port spawn_idx, output, log2(NUM_SLOTS): slot being spawned.
REQ-014 SHALL have port spawn_x, output, 10: spawn x-coordinate, range 0..607.
REQ-015 SHALL have port active_mask, output, NUM_SLOTS: bit i high when slot i is occupied.
REQ-016 SHALL have port level, output, 4: current difficulty level.

Function
REQ-017 SHALL implement states IDLE, WAIT, SEARCH, ISSUE, all registered.
REQ-018 SHALL, in IDLE: clear active_mask, set level=0, countdown=INIT_INTERVAL, interval=INIT_INTERVAL, spawn_count=0, rr_ptr=0; go to WAIT when game_screen=1.
REQ-019 SHALL, in WAIT on frame_tick: go to SEARCH if countdown==1, else decrement countdown; no frame_tick means no change.
REQ-020 SHALL, in SEARCH: pick the first clear active_mask bit scanning upward from rr_ptr with wrap; if found, latch the index and go to ISSUE; if none, set countdown=1 and return to WAIT (retry on the next frame).
REQ-021 SHALL, in ISSUE: assert spawn_valid for exactly one cycle with spawn_idx=latched index and spawn_x; set that active_mask bit; set rr_ptr=index+1 mod NUM_SLOTS; reload countdown=interval; go to WAIT.
REQ-022 SHALL increment spawn_count on every ISSUE; when it reaches RAMP_EVERY, clear it, set interval=max(interval-STEP, MIN_INTERVAL), and increment level, saturating at 15.
REQ-023 SHALL have latency: frame_tick with countdown==1 at cycle t gives SEARCH at t+1 and spawn_valid at t+2.
REQ-024 SHALL clear active_mask[free_idx] on free_valid in any non-IDLE state, including during SEARCH (the scan uses the registered mask, so the freed slot becomes visible the next cycle).
REQ-025 SHALL let set win over clear when an ISSUE set and a free_valid clear hit the same index in the same cycle; free_valid on an already-clear slot is a no-op.
REQ-026 SHALL run a 16-bit Fibonacci LFSR with taps 16,14,13,11, seeded 16'hACE1, advancing every cycle in all states.
REQ-027 SHALL form spawn_x from lfsr[9:0] at ISSUE: use it directly if <=607, else use lfsr[9:0]-512.
REQ-028 SHALL hold spawn_idx and spawn_x at their last values when spawn_valid=0.
REQ-029 SHALL, when game_screen falls in any state, enter IDLE on the next cycle with no further spawn_valid, even if the state was ISSUE-pending.

Reset
REQ-030 SHALL, on Reset=1 at a clock edge: state=IDLE, spawn_valid=0, spawn_idx=0, spawn_x=0, active_mask=0, level=0, rr_ptr=0, lfsr=16'hACE1; Reset has priority over all inputs.

Verification
REQ-031 SHALL cover: game_screen=1, 60 frame_ticks -> spawn_valid 2 cycles after the 60th tick, spawn_idx=0, active_mask=8'h01.
REQ-032 SHALL cover: all 8 slots occupied, countdown expires -> no spawn_valid; free_valid idx=5, next expiry -> spawn_idx=5.
REQ-033 SHALL cover: 10 spawns with frees -> level=1, next gap 55 frames; after 9 ramps interval stays at 15 and level keeps counting to saturate at 15.
REQ-034 SHALL cover: free_valid during SEARCH on the only free candidate -> no corruption; set/clear collision on the same idx -> bit stays set.
REQ-035 SHALL cover: game_screen falling mid-WAIT with mask=8'hFF -> IDLE, active_mask=0, level=0, no spawn_valid.
REQ-036 SHALL cover: Reset asserted in ISSUE -> spawn_valid=0 next cycle, all outputs at reset values, spawn_x always <=607.
